pl_rv32_fetch: RTL and testbench

Instruction-fetch stage of the pipelined RV32 core. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel with at most one fetch outstanding, and delivers fetched instructions to the decode stage through the IF/ID register. The stage honours decode-stage stalls via a one-entry skid buffer and handles branch/jump redirects from execute by flushing in-flight and buffered instructions.

---
 rtl/rv32_pipeline_pkg.sv | 28 ++
 rtl/pl_rv32_fetch_skid.sv | 38 +++
 rtl/pl_rv32_fetch.sv | 146 ++++++++++++++
 tb/tb_pl_rv32_fetch.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipeline_pkg.sv
// Shared types and constants for the pipelined RV32 core.
//   fetch_state_t : fetch-stage request FSM states
//   if_id_t       : one IF/ID slot (valid flag, PC, instruction word)
//   INSTR_NOP     : canonical ADDI x0,x0,0 presented when IF/ID is empty
//   IF_ID_EMPTY   : all-zero, invalid IF/ID slot used as the reset value
//   word_align()  : clears the byte-offset bits of an address
package rv32_pipeline_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
    localparam if_id_t      IF_ID_EMPTY = '{valid: 1'b0, pc: 32'd0, instr: 32'd0};

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pl_rv32_fetch_skid.sv
// One-entry skid buffer for the IF/ID register.
// Catches a fetch response that arrives while decode is stalled and the
// IF/ID register is already occupied.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_entry (caller guarantees load_entry.valid=1)
//   load_entry  : entry to capture
//   drain       : entry has been moved to IF/ID; mark empty
//   flush       : discard the entry (redirect); wins over load and drain
//   entry       : current buffer contents
module pl_rv32_fetch_skid
    import rv32_pipeline_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  if_id_t load_entry,
    input  logic   drain,
    input  logic   flush,
    output if_id_t entry
);

    if_id_t entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_reg <= IF_ID_EMPTY;
        end else if (flush) begin
            entry_reg.valid <= 1'b0;
        end else if (load) begin
            entry_reg <= load_entry;
        end else if (drain) begin
            entry_reg.valid <= 1'b0;
        end
    end

    assign entry = entry_reg;

endmodule

// File: rtl/pl_rv32_fetch.sv
// Instruction-fetch stage of the pipelined RV32 core.
// Owns the PC, issues one word fetch at a time to instruction memory and
// delivers fetched words to decode through the IF/ID register. A one-entry
// skid buffer absorbs a response that lands while decode is stalled.
// Execute-stage redirects flush IF/ID and the skid; an in-flight response
// is dropped by parking in DISCARD until it returns.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_req_valid/addr : fetch request (word address)
//   imem_req_ready      : memory accepts the request this cycle
//   imem_rsp_valid/data : in-order fetch response
//   redirect_valid/pc   : taken branch / jump target from execute
//   stall               : decode cannot consume; hold IF/ID
//   if_id_valid/pc/instr/pc_plus4 : IF/ID register outputs
module pl_rv32_fetch
    import rv32_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    logic [31:0]  pc_reg;
    logic [31:0]  req_pc_reg;
    if_id_t       out_reg;
    if_id_t       skid_entry;
    if_id_t       rsp_entry;

    logic req_fire;
    logic rsp_land;
    logic skid_load;
    logic skid_drain;

    // Responses are only meaningful in WAIT; one arriving in FETCH is a
    // protocol error and one arriving in DISCARD is stale.
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_land  = (state_reg == WAIT) && imem_rsp_valid;
    assign rsp_entry = '{valid: 1'b1, pc: req_pc_reg, instr: imem_rsp_data};

    // The response overflows into the skid only when IF/ID is full and held.
    assign skid_load  = rsp_land && out_reg.valid && stall && !redirect_valid;
    assign skid_drain = skid_entry.valid && !stall && !redirect_valid;

    pl_rv32_fetch_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .load_entry (rsp_entry),
        .drain      (skid_drain),
        .flush      (redirect_valid),
        .entry      (skid_entry)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            FETCH: begin
                // req_fire is already gated off by redirect_valid
                if (req_fire) state_next = WAIT;
            end
            WAIT: begin
                // A response in the redirect cycle is simply dropped; without
                // one, the stale response is still owed and must be swallowed.
                if (imem_rsp_valid)      state_next = FETCH;
                else if (redirect_valid) state_next = DISCARD;
            end
            DISCARD: begin
                if (imem_rsp_valid) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // No request while the skid is full, so a response can never arrive with
    // nowhere to go. Redirect retracts a pending request for a stale address.
    always_comb begin
        imem_req_valid = (state_reg == FETCH) && !skid_entry.valid && !redirect_valid;
    end

    assign imem_req_addr = pc_reg;

    // ---------------- PC and outstanding-request address ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg     <= RESET_PC;
            req_pc_reg <= 32'd0;
        end else if (redirect_valid) begin
            pc_reg <= word_align(redirect_pc);
        end else if (req_fire) begin
            req_pc_reg <= pc_reg;
            pc_reg     <= pc_reg + 32'd4;
        end
    end

    // ---------------- IF/ID register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= IF_ID_EMPTY;
        end else if (redirect_valid) begin
            out_reg.valid <= 1'b0;
        end else if (!stall) begin
            // The skid always holds the older instruction, so it goes first.
            if (skid_entry.valid) begin
                out_reg <= skid_entry;
            end else if (rsp_land) begin
                out_reg <= rsp_entry;
            end else begin
                out_reg.valid <= 1'b0;
            end
        end else if (!out_reg.valid && rsp_land) begin
            // Stalled but empty: nothing to hold, so the response fills IF/ID.
            out_reg <= rsp_entry;
        end
    end

    assign if_id_valid    = out_reg.valid;
    assign if_id_pc       = out_reg.pc;
    assign if_id_instr    = out_reg.valid ? out_reg.instr : INSTR_NOP;
    assign if_id_pc_plus4 = out_reg.pc + 32'd4;

endmodule

// File: tb/tb_pl_rv32_fetch.sv
module tb_pl_rv32_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;

    pl_rv32_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    // Stimulus knobs
    int lat_min = 1, lat_max = 1;
    int stall_pct = 0, ready_pct = 100, redir_pct = 0;
    bit force_redir = 0, redir_on_rsp = 0;
    logic [31:0] force_tgt = 0;

    // Memory model: at most one request tracked, response after lat cycles
    bit          mem_pend = 0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 0;

    // Reference model: program-order stream since the last redirect
    logic [31:0] exp_pc       = RESET_PC;
    logic [31:0] exp_req_addr = RESET_PC;

    // Bookkeeping
    int n_acc = 0, n_deliv = 0, idle = 0, max_idle = 0;
    bit last_acc = 0, last_req_valid = 0, last_rsp_redir = 0;
    bit prev_req_valid = 0, prev_acc = 0, prev_redir = 0;
    logic [31:0] prev_req_addr = 0;
    bit chk_redir = 0, chk_hold = 0;
    logic [31:0] hold_pc = 0, hold_instr = 0;
    bit wait_first = 0;
    logic [31:0] first_req = 0;

    task automatic clear_model();
        mem_pend = 0; mem_cnt = 0;
        exp_pc = RESET_PC; exp_req_addr = RESET_PC;
        prev_req_valid = 0; prev_acc = 0; prev_redir = 0;
        chk_redir = 0; chk_hold = 0; wait_first = 0;
        last_acc = 0; last_rsp_redir = 0;
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later.
    task automatic step();
        bit rsp, redir, acc, cons;
        logic [31:0] tgt;
        @(negedge clk);
        if (chk_redir) check("flush_after_redirect", {31'd0, if_id_valid}, 32'd0);
        if (chk_hold) begin
            check("stall_hold_valid", {31'd0, if_id_valid}, 32'd1);
            check("stall_hold_pc", if_id_pc, hold_pc);
            check("stall_hold_instr", if_id_instr, hold_instr);
        end
        rsp = mem_pend && (mem_cnt == 0);
        if (mem_pend && mem_cnt != 0) mem_cnt--;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
        stall          = ($urandom_range(0, 99) < stall_pct);
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        redir = 0;
        tgt   = $urandom & 32'h0000_0FFF;
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        if (force_redir || (redir_on_rsp && rsp)) begin
            redir = 1; tgt = force_tgt;
            last_rsp_redir = redir_on_rsp && rsp;
            force_redir = 0; redir_on_rsp = 0;
        end else if ($urandom_range(0, 99) < redir_pct) begin
            redir = 1;
        end
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        if (!if_id_valid) check("nop_when_empty", if_id_instr, NOP);
        if (redir) check("req_retracted_on_redirect", {31'd0, imem_req_valid}, 32'd0);
        if (imem_req_valid) check("req_addr_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
        if (prev_req_valid && !prev_acc && !prev_redir && !redir) begin
            check("req_held_valid", {31'd0, imem_req_valid}, 32'd1);
            check("req_held_addr", imem_req_addr, prev_req_addr);
        end
        acc  = imem_req_valid && imem_req_ready;
        cons = if_id_valid && !stall;
        if (rsp) mem_pend = 0;
        if (acc) begin
            check("single_outstanding", {31'd0, mem_pend}, 32'd0);
            check("req_addr", imem_req_addr, exp_req_addr);
            exp_req_addr = exp_req_addr + 32'd4;
            mem_pend = 1;
            mem_cnt  = $urandom_range(lat_min, lat_max) - 1;
            mem_addr = imem_req_addr;
            n_acc++;
            if (wait_first) begin first_req = imem_req_addr; wait_first = 0; end
        end
        if (cons) begin
            check("deliver_pc", if_id_pc, exp_pc);
            check("deliver_instr", if_id_instr, mem_word(exp_pc));
            check("deliver_pc_plus4", if_id_pc_plus4, exp_pc + 32'd4);
            $display("deliver pc=%h instr=%h", if_id_pc, if_id_instr);
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
        if (redir) begin
            exp_pc       = tgt & 32'hFFFF_FFFC;
            exp_req_addr = tgt & 32'hFFFF_FFFC;
            wait_first   = 1;
        end
        if (acc || cons) idle = 0; else idle++;
        if (idle > max_idle) max_idle = idle;
        chk_redir  = redir;
        chk_hold   = if_id_valid && stall && !redir;
        hold_pc    = if_id_pc;
        hold_instr = if_id_instr;
        prev_req_valid = imem_req_valid;
        prev_req_addr  = imem_req_addr;
        prev_acc       = acc;
        prev_redir     = redir;
        last_acc       = acc;
        last_req_valid = imem_req_valid;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; stall = 0;
    endtask

    task automatic set_mode(input int lmin, input int lmax, input int st, input int rd, input int rr);
        lat_min = lmin; lat_max = lmax; stall_pct = st; ready_pct = rd; redir_pct = rr;
    endtask

    int a0, d0;
    bit got_it;

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        check("reset_if_id_pc", if_id_pc, 32'd0);
        check("reset_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("reset_req_addr", imem_req_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1;
        clear_model();

        // Zero-wait memory, no stall: one instruction per two cycles
        set_mode(1, 1, 0, 100, 0);
        a0 = n_acc; d0 = n_deliv;
        repeat (20) step();
        check("k1_accepts_in_20", n_acc - a0, 32'd10);
        check("k1_delivers_in_20", n_deliv - d0, 32'd9);

        // Long stall: skid fills, then requests stop
        got_it = 0;
        for (int i = 0; i < 10 && !got_it; i++) begin step(); got_it = if_id_valid; end
        check("stall_setup", {31'd0, got_it}, 32'd1);
        stall_pct = 100;
        a0 = n_acc;
        repeat (6) step();
        check("stall_one_more_accept", n_acc - a0, 32'd1);
        check("stall_req_blocked", {31'd0, last_req_valid}, 32'd0);
        stall_pct = 0;
        d0 = n_deliv;
        repeat (8) step();
        check("stall_release_progress", {31'd0, (n_deliv - d0) >= 3}, 32'd1);

        // Redirect in WAIT with a late response -> DISCARD
        set_mode(3, 3, 0, 100, 0);
        got_it = 0;
        for (int i = 0; i < 20 && !got_it; i++) begin step(); got_it = last_acc; end
        check("discard_setup", {31'd0, got_it}, 32'd1);
        force_redir = 1; force_tgt = 32'h0000_0100;
        d0 = n_deliv;
        repeat (16) step();
        check("discard_first_req", first_req, 32'h0000_0100);
        check("discard_resume", {31'd0, (n_deliv - d0) >= 2}, 32'd1);

        // Redirect coinciding with a response
        set_mode(2, 2, 0, 100, 0);
        redir_on_rsp = 1; force_tgt = 32'h0000_0040; last_rsp_redir = 0;
        for (int i = 0; i < 20 && redir_on_rsp; i++) step();
        check("rsp_redir_happened", {31'd0, last_rsp_redir}, 32'd1);
        repeat (10) step();
        check("rsp_redir_first_req", first_req, 32'h0000_0040);

        // Misaligned redirect target
        set_mode(1, 1, 0, 100, 0);
        force_redir = 1; force_tgt = 32'h0000_0203;
        repeat (10) step();
        check("misaligned_first_req", first_req, 32'h0000_0200);

        // Address wrap at 2^32
        force_redir = 1; force_tgt = 32'hFFFF_FFFC;
        d0 = n_deliv;
        repeat (12) step();
        check("wrap_first_req", first_req, 32'hFFFF_FFFC);
        check("wrap_delivered", {31'd0, (n_deliv - d0) >= 3}, 32'd1);

        // Randomized traffic
        set_mode(1, 4, 30, 70, 5);
        max_idle = 0; idle = 0;
        d0 = n_deliv;
        repeat (3000) step();
        check("random_no_hang", {31'd0, max_idle <= 60}, 32'd1);
        check("random_progress", {31'd0, (n_deliv - d0) >= 300}, 32'd1);

        // Reset asserted while a fetch is outstanding and IF/ID is full
        set_mode(3, 3, 100, 100, 0);
        got_it = 0;
        for (int i = 0; i < 30 && !got_it; i++) begin step(); got_it = if_id_valid && mem_pend; end
        check("midreset_setup", {31'd0, got_it}, 32'd1);
        #1;
        rst_n = 0;
        idle_inputs();
        #1;
        check("midreset_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        check("midreset_instr_nop", if_id_instr, NOP);
        check("midreset_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("midreset_req_addr", imem_req_addr, RESET_PC);
        repeat (2) @(negedge clk);
        rst_n = 1;
        clear_model();
        set_mode(1, 2, 20, 80, 0);
        d0 = n_deliv;
        repeat (30) step();
        check("post_reset_progress", {31'd0, (n_deliv - d0) >= 3}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard bound in case a wait above ever stalls the clock-driven flow
    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
